// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: Tick/Rx in, received word and status pulses out,
// plus a debug view of the receiver FSM state.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 Tick;
    logic                 Rx;
    logic [DATA_BITS-1:0] Data;
    logic                 Valid;
    logic                 FrameError;
    logic                 ParityError;
    logic [2:0]           state_dbg;

    // Valid/FrameError/ParityError are one-cycle pulses with no back-pressure: Data is
    // meaningful in the cycle a pulse is high and holds until the next pulse.
    modport slave (
        input  Tick, Rx,
        output Data, Valid, FrameError, ParityError, state_dbg
    );

    modport master (
        output Tick, Rx,
        input  Data, Valid, FrameError, ParityError, state_dbg
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, mid-bit sampling FSM, registered pulses.
// Optional even-parity bit enabled with macro UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input logic      Clock,
    input logic      Reset,
    uart_rx_if.slave bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 parity_error_q, parity_error_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
`endif

    always_comb begin
        rx_meta_d      = bus.Rx;
        rx_s_d         = rx_meta_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        data_d         = data_q;
        valid_d        = 1'b0;
        frame_error_d  = 1'b0;
        parity_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d      = par_bad_q;
`endif
        // Nothing but the pulse outputs may move on a Tick-free cycle.
        if (bus.Tick) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s_q) state_d = S_START;
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = rx_s_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        par_bad_d = rx_s_q ^ (^shift_q);
                        state_d   = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        data_d = shift_q;
                        if (rx_s_q) begin
                            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_error_d = par_bad_q;
`endif
                            state_d = S_IDLE;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line (break) must go high before a new start can be seen.
                    cnt_d = '0;
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            rx_meta_q      <= 1'b1;
            rx_s_q         <= 1'b1;
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            frame_error_q  <= 1'b0;
            parity_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            rx_meta_q      <= rx_meta_d;
            rx_s_q         <= rx_s_d;
            cnt_q          <= cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            frame_error_q  <= frame_error_d;
            parity_error_q <= parity_error_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q      <= par_bad_d;
`endif
        end
    end

    assign bus.Data        = data_q;
    assign bus.Valid       = valid_q;
    assign bus.FrameError  = frame_error_q;
    assign bus.ParityError = parity_error_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, Tick pulses per bit period (even, >=8).
REQ-003 SHALL have port Clock  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Tick  input  1  oversample strobe, one Clock cycle wide, from the modulo-N baud counter.
REQ-006 SHALL have port Rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port Data  output  DATA_BITS  last received word, LSB first on line.
REQ-008 SHALL have port Valid  output  1  one-cycle pulse when Data holds a new good frame.
REQ-009 SHALL have port FrameError  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port ParityError  output  1  one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-011 SHALL pass Rx through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value RxS.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-013 SHALL use a tick counter of $clog2(OVERSAMPLE) bits, advanced only on Tick, cleared on every state change.
REQ-014 IDLE: on a Tick with RxS=0, SHALL enter START with the tick counter cleared.
REQ-015 START: on the Tick on which the counter reaches OVERSAMPLE/2-1, SHALL sample RxS; 0 -> DATA, 1 -> IDLE (false start, no output pulse).
REQ-016 DATA: SHALL sample RxS on each Tick at counter OVERSAMPLE-1 (bit-period midpoint), shift it into the MSB of the shift register, and after DATA_BITS samples enter PARITY (macro defined) or STOP.
REQ-017 STOP: SHALL sample RxS at counter OVERSAMPLE-1; 1 -> load Data, pulse Valid next cycle, go IDLE; 0 -> load Data, pulse FrameError, no Valid, go WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL stay until a Tick with RxS=1, then go IDLE (break and line-low protection).
REQ-019 Data SHALL change only in the cycle Valid or FrameError asserts, and hold otherwise.
REQ-020 Valid, FrameError and ParityError SHALL be registered, each high for exactly one Clock cycle per event.
REQ-021 A Tick-free cycle SHALL never change state, counters or outputs, except that the pulse outputs drop.
REQ-022 Latency, Rx edge to Valid, SHALL be 2 sync cycles plus (DATA_BITS+1.5)*OVERSAMPLE Ticks (+OVERSAMPLE with parity) plus 1 cycle.
REQ-023 A start bit arriving while in STOP SHALL NOT be detected until IDLE is reached.

Reset
REQ-024 Reset SHALL force IDLE, counters 0, shift register 0, Data 0, Valid/FrameError/ParityError 0, synchronizer 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output pulse; reception resumes on the next falling edge after release.
REQ-026 Reset SHALL take priority over Tick in the same cycle.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: SHALL insert PARITY after DATA, sampling one even-parity bit at counter OVERSAMPLE-1; on mismatch SHALL pulse ParityError with Valid, and Data is still loaded.
REQ-028 Macro UART_RX_PARITY_EN undefined: SHALL omit the PARITY state and hold ParityError constant 0.

Verification
REQ-029 OVERSAMPLE=16, Tick every cycle, frame 0x55 with stop=1 -> Valid one cycle, Data=0x55, FrameError=0.
REQ-030 Rx low for 4 Ticks, then high -> no Valid or FrameError pulse, FSM back in IDLE, next frame 0xA3 received correctly.
REQ-031 Frame 0x3C with stop=0, line held low 40 Ticks -> FrameError once, Data=0x3C, no Valid, no new start until Rx returns high.
REQ-032 Reset pulsed at bit 4 of frame 0xFF, then frame 0x12 sent -> no pulse for the aborted frame, Valid with Data=0x12.
REQ-033 Tick every 3rd cycle (counter N=3), back-to-back frames 0x00 and 0xFF -> two Valid pulses, Data 0x00 then 0xFF.
REQ-034 UART_RX_PARITY_EN: 0x07 with parity 1 (correct) -> Valid, ParityError=0; same frame with parity 0 -> Valid and ParityError together, Data=0x07.
